// File: rtl/dw02_mac.sv
// rtl/dw02_mac.sv - multiplier-accumulator MAC = A*B + C, unsigned or two's complement, optional output register
module dw02_mac #(
  parameter int A_width     = 8,
  parameter int B_width     = 8,
  parameter int PIPE_STAGES = 0
) (
  input  logic                       MAC_ACC_CLK,
  input  logic                       acc_ff_rstn,
  input  logic [A_width-1:0]         A,
  input  logic [B_width-1:0]         B,
  input  logic [A_width+B_width-1:0] C,
  input  logic                       TC,
  output logic [A_width+B_width-1:0] MAC
);

  localparam int W = A_width + B_width;

  logic [W-1:0] a_ext;
  logic [W-1:0] b_ext;
  logic [W-1:0] prod;
  logic [W-1:0] mac_comb;

  // Extending both operands to W bits makes a plain modulo-2^W multiply sign-correct.
  always_comb begin
    a_ext    = TC ? {{B_width{A[A_width-1]}}, A} : {{B_width{1'b0}}, A};
    b_ext    = TC ? {{A_width{B[B_width-1]}}, B} : {{A_width{1'b0}}, B};
    prod     = a_ext * b_ext;
    mac_comb = prod + C;
  end

  generate
    if (PIPE_STAGES == 1) begin : g_pipe
      logic [W-1:0] mac_q;

      always_ff @(posedge MAC_ACC_CLK or negedge acc_ff_rstn) begin
        if (!acc_ff_rstn) begin
          mac_q <= '0;
        end else begin
          mac_q <= mac_comb;
        end
      end

      assign MAC = mac_q;
    end else begin : g_comb
      // Clock and reset have no function in the combinational build.
      logic unused_clk_rst;
      assign unused_clk_rst = MAC_ACC_CLK ^ acc_ff_rstn;
      assign MAC = mac_comb;
    end
  endgenerate

endmodule

// File: tb/tb_dw02_mac.sv
// tb/tb_dw02_mac.sv - directed self-checking bench for dw02_mac, combinational and pipelined builds
module tb_dw02_mac;

  localparam int AW = 12;
  localparam int BW = 12;
  localparam int W  = AW + BW;

  logic          clk;
  logic          rstn;
  logic [AW-1:0] a_c,  a_p;
  logic [BW-1:0] b_c,  b_p;
  logic [W-1:0]  c_c,  c_p;
  logic          tc_c, tc_p;
  logic [W-1:0]  mac_c, mac_p;

  int n_checks = 0;
  int n_fails  = 0;

  dw02_mac #(.A_width(AW), .B_width(BW), .PIPE_STAGES(0)) u_comb (
    .MAC_ACC_CLK (clk),
    .acc_ff_rstn (rstn),
    .A           (a_c),
    .B           (b_c),
    .C           (c_c),
    .TC          (tc_c),
    .MAC         (mac_c)
  );

  dw02_mac #(.A_width(AW), .B_width(BW), .PIPE_STAGES(1)) u_pipe (
    .MAC_ACC_CLK (clk),
    .acc_ff_rstn (rstn),
    .A           (a_p),
    .B           (b_p),
    .C           (c_p),
    .TC          (tc_p),
    .MAC         (mac_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fails++;
      $display("FAIL %s: got 0x%06h, expected 0x%06h", tag, obs, exp_v);
    end
  endtask

  task automatic apply_comb(input logic tc, input logic [AW-1:0] a, input logic [BW-1:0] b, input logic [W-1:0] c);
    tc_c = tc;
    a_c  = a;
    b_c  = b;
    c_c  = c;
    #1;
  endtask

  initial begin
    rstn = 1'b0;
    a_p = '0; b_p = '0; c_p = '0; tc_p = 1'b0;
    apply_comb(1'b0, 12'h000, 12'h000, 24'h000000);

    apply_comb(1'b0, 12'hFFF, 12'hFFF, 24'h000000); check_val("unsigned_max",   mac_c, 24'hFFE001);
    apply_comb(1'b0, 12'h0FF, 12'h0FF, 24'h000000); check_val("unsigned_ff",    mac_c, 24'h00FE01);
    apply_comb(1'b0, 12'hFFF, 12'hFFF, 24'hFFFFFF); check_val("unsigned_wrap",  mac_c, 24'hFFE000);
    apply_comb(1'b0, 12'h123, 12'h010, 24'h000005); check_val("unsigned_add",   mac_c, 24'h001235);
    apply_comb(1'b1, 12'hFFF, 12'h003, 24'h00000A); check_val("signed_m1x3",    mac_c, 24'h000007);
    apply_comb(1'b1, 12'hF80, 12'hF80, 24'h000000); check_val("signed_m128sq",  mac_c, 24'h004000);
    apply_comb(1'b1, 12'h800, 12'h800, 24'h000000); check_val("signed_extreme", mac_c, 24'h400000);
    apply_comb(1'b1, 12'h800, 12'h800, 24'hC00000); check_val("signed_ext_c",   mac_c, 24'h000000);
    apply_comb(1'b1, 12'h005, 12'hFFE, 24'hFFFFFF); check_val("signed_neg_c",   mac_c, 24'hFFFFF5);
    apply_comb(1'b0, 12'hFFF, 12'h002, 24'h000000); check_val("tc_toggle_0",    mac_c, 24'h001FFE);
    tc_c = 1'b1; #1;                                check_val("tc_toggle_1",    mac_c, 24'hFFFFFE);
    tc_c = 1'b0; #1;                                check_val("tc_toggle_back", mac_c, 24'h001FFE);

    // Pipelined build
    a_p = 12'd3; b_p = 12'd4; c_p = 24'd5; tc_p = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("pipe_reset_hold", mac_p, 24'h000000);
    rstn = 1'b1;
    #1;
    check_val("pipe_no_edge_yet", mac_p, 24'h000000);
    @(posedge clk); #1;
    check_val("pipe_first",      mac_p, 24'd17);
    @(negedge clk);
    a_p = 12'd5; b_p = 12'd5; c_p = 24'd1;
    #1;
    check_val("pipe_latency",    mac_p, 24'd17);
    @(posedge clk); #1;
    check_val("pipe_second",     mac_p, 24'd26);
    @(negedge clk);
    tc_p = 1'b1; a_p = 12'hFFF; b_p = 12'h002; c_p = 24'h0;
    @(posedge clk); #1;
    check_val("pipe_signed",     mac_p, 24'hFFFFFE);
    @(negedge clk);
    a_p = 12'd7; b_p = 12'd7; c_p = 24'd0;
    #2;
    rstn = 1'b0;
    #1;
    check_val("pipe_async_rst",  mac_p, 24'h000000);
    @(posedge clk); #1;
    check_val("pipe_rst_held",   mac_p, 24'h000000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/dw02_mac.md
# dw02_mac

Parameterised multiplier-accumulator datapath: computes MAC = A × B + C in unsigned or two's-complement arithmetic, selected at run time by TC. It is the arithmetic core of the 8-bit MAC slice in the eFPGA math unit. The slice feeds sign-extended 12-bit operands and a 24-bit feedback term (accumulator, rounding constant, or zero) into C. An optional output register is selectable by parameter; the default build is purely combinational.

## Interface
- A_width, default 8: width of operand A; the math unit uses 12.
- B_width, default 8: width of operand B; the math unit uses 12.
- PIPE_STAGES, default 0: 0 gives a combinational MAC output; 1 registers MAC on MAC_ACC_CLK. No other values are legal.
- MAC_ACC_CLK  input  1  clock; used only when PIPE_STAGES=1.
- acc_ff_rstn  input  1  reset, asynchronous, active-low; used only when PIPE_STAGES=1.
- A  input  A_width  multiplicand.
- B  input  B_width  multiplier.
- C  input  A_width+B_width  addend.
- TC  input  1  0 = unsigned operands; 1 = two's-complement operands.
- MAC  output  A_width+B_width  result.

## Operation
- Let W = A_width + B_width. All arithmetic is modulo 2^W.
- TC=0:
  - A, B and C are unsigned.
  - MAC = (A × B + C) mod 2^W.
- TC=1:
  - A, B and C are two's complement.
  - The product is sign-correct; it always fits in W bits.
  - MAC = (A × B + C) mod 2^W, interpreted as two's complement.
- Overflow of the addition wraps silently. There is no saturation and no carry-out; saturation is the parent's job.
- TC is a live input and may change on any cycle; the result follows immediately.
- Most-negative operands are legal. With TC=1, A = -2^(A_width-1) and B = -2^(B_width-1) gives the positive product 2^(W-2).
- The parent performs sign extension of 8-bit data to 12 bits. This block always treats the full A_width/B_width inputs as the operand.
- No X-propagation masking: an X on any input may produce X on MAC.

## Timing
- PIPE_STAGES=0:
  - MAC is a pure combinational function of A, B, C and TC, with zero latency.
  - Clock and reset are ignored and may be left unconnected.
- PIPE_STAGES=1:
  - MAC is registered on the rising edge of MAC_ACC_CLK; latency is 1 cycle. There is no enable; the register loads every cycle.
  - acc_ff_rstn low forces MAC to 0 asynchronously and holds it at 0 while low.
  - The first valid result appears on the first rising edge after reset deasserts.
  - Reset asserted mid-operation discards the pending result; MAC goes to 0 immediately.
- The combinational path must close timing in one MAC_ACC_CLK period at W=24. The parent's accumulator register sits directly on MAC.

## Test plan
All vectors use A_width = B_width = 12 (W = 24), PIPE_STAGES = 0 unless noted.
- Unsigned max: TC=0, A=0xFFF, B=0xFFF, C=0 -> MAC=0xFFE001. Also A=0x0FF, B=0x0FF, C=0 -> 0x00FE01.
- Unsigned wrap: TC=0, A=0xFFF, B=0xFFF, C=0xFFFFFF -> MAC=0xFFE000 (carry discarded).
- Signed mixed: TC=1, A=0xFFF (-1), B=0x003, C=0x00000A -> MAC=0x000007. Also A=0xF80 (-128), B=0xF80 (-128), C=0 -> 0x004000.
- Signed extreme: TC=1, A=0x800, B=0x800, C=0 -> MAC=0x400000. Then C=0xC00000 -> 0x000000.
- TC toggle: A=0xFFF, B=0x002, C=0. TC=0 -> 0x001FFE; TC=1 -> 0xFFFFFE. The change must take effect combinationally, with no clock.
- Pipelined build (PIPE_STAGES=1):
  - Hold reset low -> MAC=0.
  - Release reset and apply A=3, B=4, C=5, TC=0 -> MAC=17 one edge later.
  - Assert reset mid-stream -> MAC=0 without waiting for a clock edge.
